ysyx_22041412_mul_iter: RTL and testbench
=========================================

# ysyx_22041412_mul_iter

Parametrised iterative radix-4 Booth multiplier for the EXU, the successor of the fixed 64-bit multiplier. It takes XLEN-bit operands with full RV64M signedness and word-mode semantics, retires UNROLL Booth digits per cycle, and returns the low or high XLEN bits of the product. Input and output use valid/ready handshakes, and a flush aborts the operation.

## Interface
- XLEN, 64: operand/result width; even, ≥ 32
- UNROLL, 1: Booth digits (2 multiplier bits each) accumulated per BUSY cycle; 1, 2 or 4
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-low
- flush  in  1  abandon current operation
- in_valid  in  1  operation request
- in_ready  out  1  high only in IDLE
- multiplicand_i  in  XLEN  operand A
- multiplier_i  in  XLEN  operand B
- mul_signed  in  2  11 s×s, 10 s(A)×u(B), 00 u×u; 01 treated as 00
- mulw_i  in  1  word mode: low 32 bits of operands, 32-bit result
- mul_hi  in  1  return product[2·XLEN-1:XLEN]; ignored when mulw_i=1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result_o  out  XLEN  result

## Operation
- States: IDLE, BUSY, DONE.
- IDLE → BUSY when in_valid & in_ready & ~flush. This edge latches the operands and the mode bits, and clears the accumulator.
- Operand extension:
  - The multiplicand register is 2·XLEN+2 bits wide. It is sign-extended when mul_signed[1] is set, otherwise zero-extended. In word mode, bit 31 is the extension source.
  - The multiplier register is XLEN+3 bits wide: {ext, ext, B, 1'b0}. ext is B's MSB when mul_signed[0] is set, otherwise 0. In word mode, bits 63:32 are replaced by the extension of bit 31.
- Each BUSY cycle, for each of the UNROLL digits:
  - The digit is selected from multiplier bits [2:0]: 0, ±A or ±2A.
  - It is added to the accumulator, modulo 2^(2·XLEN+2).
  - The multiplicand is shifted left 2 and the multiplier right 2 (arithmetic shift).
- Digit count D = XLEN/2+1, or 17 in word mode. The number of BUSY cycles is K = ceil(D/UNROLL).
- After the last BUSY cycle, the FSM moves to DONE and registers result_o:
  - mulw_i=1: sign-extend product[31:0] to XLEN.
  - Otherwise mul_hi selects the high half, and its absence selects the low half.
- DONE holds result_o and out_valid until out_ready=1. It then returns to IDLE.
- flush in any state: next state is IDLE and out_valid drops; a pending result is discarded. An in_valid in the same cycle as flush is not accepted.
- Async reset (rst low) at any time, including mid-BUSY:
  - state is IDLE and in_ready=1;
  - out_valid=0 and result_o=0;
  - the internal registers are 0.

## Timing
- Acceptance edge is cycle 0. BUSY occupies cycles 1..K and out_valid is high from cycle K+1.
- Example: XLEN=64, UNROLL=1 gives 34 cycles (word mode: 18). XLEN=64, UNROLL=2 gives 18 cycles.
- out_valid and result_o are registered, with no combinational path from in_* to out_*.
- in_ready depends only on state. Throughput is one operation per K+2 cycles at best, because there is no back-to-back acceptance in DONE.

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - At the start of a BUSY cycle, if the whole remaining multiplier register is all-0 or all-1, the remaining digits are zero. That cycle performs no accumulation and the next state is DONE.
  - Latency is data-dependent, with a minimum of 2 cycles (out_valid in cycle 2).
- Not defined: fixed latency K+1, and no detection logic is present.
- Results are identical in both builds.

## Structure
- Package ysyx_22041412_mul_pkg holds:
  - the state enum;
  - the mul_signed encodings;
  - the word-mode digit count constant;
  - the localparam function for K.
- Sub-module ysyx_22041412_booth_pp(WIDTH):
  - combinational partial product from a 3-bit code and the multiplicand;
  - instantiated UNROLL times, with copy i fed by multiplicand<<2i and bits [2i+2:2i].

## Test plan
- XLEN=64, s×s, A=B=0xFFFF_FFFF_FFFF_FFFF, mul_hi=0 → result 0x1; mul_hi=1 → 0x0. out_valid exactly 34 cycles after acceptance (no EARLY_EXIT).
- u×u, A=B=0xFFFF_FFFF_FFFF_FFFF, mul_hi=1 → 0xFFFF_FFFF_FFFF_FFFE. s×u, A=-1, B=0xFFFF_FFFF_FFFF_FFFF, mul_hi=1 → 0xFFFF_FFFF_FFFF_FFFF.
- mulw_i=1, A=0x7FFF_FFFF, B=2 → 0xFFFF_FFFF_FFFF_FFFE, out_valid 18 cycles after acceptance. Operand upper bits set to garbage do not change the result.
- Backpressure:
  - out_ready held low for 5 cycles → result_o and out_valid stable and in_ready=0.
  - On the first cycle out_ready is high, the FSM returns to IDLE.
- flush asserted in BUSY cycle 10 → out_valid never rises for that operation, and in_ready=1 the next cycle. rst pulsed low mid-BUSY → all outputs return to reset values immediately.
- With MUL_EARLY_EXIT_EN: A=5, B=3 → result 15 with out_valid in cycle 4. B=0 → result 0 with out_valid in cycle 2.

Source files
------------

// File: rtl/ysyx_22041412_mul_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier.
//   mul_state_e : FSM states
//   MS_*        : mul_signed encodings (2'b01 behaves like MS_UU)
//   WORD_DIGITS : Booth digits needed for a 32-bit word-mode product
//   calc_k()    : BUSY cycles for a digit count at a given unroll
package ysyx_22041412_mul_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } mul_state_e;

   localparam logic [1:0] MS_SS = 2'b11;
   localparam logic [1:0] MS_SU = 2'b10;
   localparam logic [1:0] MS_UU = 2'b00;

   localparam int WORD_DIGITS = 17;

   function automatic int calc_k(input int digits, input int unroll);
      return (digits + unroll - 1) / unroll;
   endfunction

endpackage

// File: rtl/ysyx_22041412_mul_iter_booth_pp.sv
// Radix-4 Booth partial-product selector (purely combinational).
//   code_i  : multiplier bits {b[2i+1], b[2i], b[2i-1]}
//   mcand_i : multiplicand, already aligned to this digit's weight
//   pp_o    : 0, +-mcand or +-2*mcand, modulo 2^WIDTH
module ysyx_22041412_booth_pp #(
   parameter int WIDTH = 130
) (
   input  logic [2:0]       code_i,
   input  logic [WIDTH-1:0] mcand_i,
   output logic [WIDTH-1:0] pp_o
);

   always_comb begin
      pp_o = '0;
      case (code_i)
         3'b001, 3'b010: pp_o = mcand_i;
         3'b011:         pp_o = mcand_i << 1;
         3'b100:         pp_o = -(mcand_i << 1);
         3'b101, 3'b110: pp_o = -mcand_i;
         default:        pp_o = '0;
      endcase
   end

endmodule

// File: rtl/ysyx_22041412_mul_iter.sv
// Iterative radix-4 Booth multiplier, UNROLL digits per BUSY cycle.
// Ports:
//   clk, rst (async, active-low), flush (abort current operation)
//   in_valid/in_ready       : request handshake, in_ready high only in IDLE
//   multiplicand_i, multiplier_i, mul_signed, mulw_i, mul_hi : operation
//   out_valid/out_ready     : result handshake, result_o registered
// Build option: MUL_EARLY_EXIT_EN finishes as soon as the remaining
// multiplier bits are all-0 or all-1 (no further nonzero digits).
module ysyx_22041412_mul_iter
   import ysyx_22041412_mul_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] multiplicand_i,
   input  logic [XLEN-1:0] multiplier_i,
   input  logic [1:0]      mul_signed,
   input  logic            mulw_i,
   input  logic            mul_hi,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result_o
);

   localparam int AW     = 2 * XLEN + 2;
   localparam int BW     = XLEN + 3;
   localparam int K_FULL = calc_k(XLEN / 2 + 1, UNROLL);
   localparam int K_WORD = calc_k(WORD_DIGITS, UNROLL);
   localparam int CW     = $clog2(XLEN);

   mul_state_e state_q, state_d;
   logic [AW-1:0]   mcand_q, mcand_d;
   logic [BW-1:0]   mplr_q, mplr_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            w_q, w_d;
   logic            hi_q, hi_d;
   logic [XLEN-1:0] result_q, result_d;

   logic [UNROLL-1:0][AW-1:0] pp;
   logic [AW-1:0]   acc_sum;
   logic [AW-1:0]   prod_fin;
   logic [XLEN-1:0] res_sel;
   logic [AW-1:0]   a_ext;
   logic [BW-1:0]   b_ext;
   logic            a_sign, b_sign;
   logic            early_exit;

   // Operand extension; in word mode bit 31 is the sign source and the
   // upper operand bits are never looked at.
   always_comb begin
      a_sign = mul_signed[1] & (mulw_i ? multiplicand_i[31] : multiplicand_i[XLEN-1]);
      b_sign = (mul_signed == MS_SS) & (mulw_i ? multiplier_i[31] : multiplier_i[XLEN-1]);
      if (mulw_i) begin
         a_ext = AW'($signed({a_sign, multiplicand_i[31:0]}));
         b_ext = BW'($signed({b_sign, multiplier_i[31:0], 1'b0}));
      end else begin
         a_ext = AW'($signed({a_sign, multiplicand_i}));
         b_ext = {b_sign, b_sign, multiplier_i, 1'b0};
      end
   end

   // Copy g handles the digit at multiplier bits [2g+2:2g] of this cycle.
   for (genvar g = 0; g < UNROLL; g++) begin : g_pp
      ysyx_22041412_booth_pp #(.WIDTH(AW)) u_pp (
         .code_i  (mplr_q[2*g+2 -: 3]),
         .mcand_i (mcand_q << (2 * g)),
         .pp_o    (pp[g])
      );
   end

   always_comb begin
      acc_sum = acc_q;
      for (int i = 0; i < UNROLL; i++) acc_sum = acc_sum + pp[i];
   end

`ifdef MUL_EARLY_EXIT_EN
   // Arithmetic shifts keep the register sign-filled, so an all-equal
   // register means every remaining digit decodes to zero.
   assign early_exit = (&mplr_q) | (~|mplr_q);
`else
   assign early_exit = 1'b0;
`endif

   // On an early exit nothing is added this cycle, so the product is acc_q.
   always_comb begin
      prod_fin = early_exit ? acc_q : acc_sum;
      if (w_q)       res_sel = XLEN'($signed(prod_fin[31:0]));
      else if (hi_q) res_sel = prod_fin[2*XLEN-1:XLEN];
      else           res_sel = prod_fin[XLEN-1:0];
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      w_d      = w_q;
      hi_d     = hi_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_BUSY;
               mcand_d = a_ext;
               mplr_d  = b_ext;
               acc_d   = '0;
               cnt_d   = mulw_i ? CW'(K_WORD - 1) : CW'(K_FULL - 1);
               w_d     = mulw_i;
               hi_d    = mul_hi;
            end
         end
         S_BUSY: begin
            if (early_exit) begin
               state_d  = S_DONE;
               result_d = res_sel;
            end else begin
               acc_d   = acc_sum;
               mcand_d = mcand_q << (2 * UNROLL);
               mplr_d  = BW'($signed(mplr_q) >>> (2 * UNROLL));
               if (cnt_q == '0) begin
                  state_d  = S_DONE;
                  result_d = res_sel;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplr_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         w_q      <= 1'b0;
         hi_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplr_q   <= mplr_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         w_q      <= w_d;
         hi_q     <= hi_d;
         result_q <= result_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result_o  = result_q;

endmodule

// File: tb/tb_ysyx_22041412_mul_iter.sv
module tb_ysyx_22041412_mul_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic [1:0]  mul_signed = 2'b00;
   logic        mulw_i = 1'b0;
   logic        mul_hi = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] result_o;

`ifdef MUL_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   seen = 1'b0;

   ysyx_22041412_mul_iter #(.XLEN(64), .UNROLL(1)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .multiplicand_i (a),
      .multiplier_i   (b),
      .mul_signed     (mul_signed),
      .mulw_i         (mulw_i),
      .mul_hi         (mul_hi),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .result_o       (result_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Latency is reported as the cycle index of first out_valid, the
   // acceptance edge being cycle 0 (34 for a full 64-bit op, 18 word).
   always begin
      @(negedge clk);
      #1;
      if (!out_valid) seen = 1'b0;
      if (rst && out_valid) begin
         if (!seen) begin
            seen = 1'b1;
            if (sbq.size() > 0 && sbq[0].lat != 0)
               chk("latency", 64'(cyc - sbq[0].acc_cyc + 1), 64'(sbq[0].lat));
         end
         if (out_ready) begin
            if (sbq.size() == 0) begin
               chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("result", result_o, e.res);
            end
            seen = 1'b0;
         end
      end
   end

   task automatic issue(input logic [63:0] ta, input logic [63:0] tbv, input logic [1:0] ms,
                        input bit w, input bit hi, input logic [63:0] res,
                        input int ee_lat, input bit push);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("issue_timeout", 64'(in_ready), 64'd1);
         return;
      end
      a = ta; b = tbv; mul_signed = ms; mulw_i = w; mul_hi = hi; in_valid = 1'b1;
      if (push) begin
         e.res = res;
         e.lat = EE ? ee_lat : (w ? 18 : 34);
         e.acc_cyc = cyc + 1;
         sbq.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
   endtask

   initial begin
      int n;
      int vcount;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 0, 0, 64'h1, 0, 1);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 0, 1, 64'h0, 0, 1);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
      issue(64'h0000_0000_7FFF_FFFF, 64'h2, 2'b11, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1);
      issue(64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 2'b11, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1);
      issue(64'd5, 64'd3, 2'b11, 0, 0, 64'd15, 4, 1);
      issue(64'd5, 64'd0, 2'b11, 0, 0, 64'd0, 2, 1);
      issue(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 2'b11, 0, 0, 64'hFFFF_FFFF_FFFF_FFEB, 0, 1);
      issue(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 2'b11, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b01, 0, 1, 64'h1, 0, 1);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b01, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1);
      issue(64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1, 0, 64'h1, 0, 1);
      issue(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 2'b00, 0, 1, 64'h1, 0, 1);
      issue(64'h8000_0000_0000_0000, 64'd2, 2'b10, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
      issue(64'h8000_0000_0000_0000, 64'd2, 2'b10, 0, 0, 64'h0, 0, 1);
      issue(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_8000_0000, 2'b11, 1, 0, 64'hFFFF_FFFF_8000_0000, 0, 1);
      drain();

      // Backpressure: result and handshake state hold while out_ready is low.
      out_ready = 1'b0;
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!out_valid && n < 100);
      repeat (5) begin
         @(negedge clk);
         #1;
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_result", result_o, 64'hFFFF_FFFF_FFFF_FFFE);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_release_in_ready", 64'(in_ready), 64'd1);
      chk("bp_release_out_valid", 64'(out_valid), 64'd0);
      drain();

      // Flush in BUSY cycle 10: the operation never produces a result.
      issue(64'd9, 64'd9, 2'b11, 0, 0, 64'd81, 0, 0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_out_valid", 64'(out_valid), 64'd0);

      // in_valid together with flush is not accepted.
      @(negedge clk);
      a = 64'd5; b = 64'd3; mul_signed = 2'b11; mulw_i = 1'b0; mul_hi = 1'b0;
      in_valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      flush = 1'b0;
      #1;
      chk("flush_in_valid_in_ready", 64'(in_ready), 64'd1);
      vcount = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (out_valid) vcount++;
      end
      chk("flush_no_out_valid", 64'(vcount), 64'd0);

      // Async reset mid-BUSY: outputs drop without waiting for a clock edge.
      issue(64'd7, 64'd6, 2'b11, 0, 0, 64'd42, 0, 0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
      chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      issue(64'd5, 64'd3, 2'b11, 0, 0, 64'd15, 4, 1);
      issue(64'd7, 64'd6, 2'b00, 0, 0, 64'd42, 0, 1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
